rs_syndrome: RTL and testbench

Streaming Reed-Solomon syndrome calculator: the first stage of the RS decoder, directly upstream of Berlekamp-Massey. It accepts a received codeword of `N_LEN` symbols, `BUS_WIDTH_IN_SYMB` symbols per beat. It produces `ROOTS_NUM` syndromes S_j = r(alpha^(FIRST_ROOT+j)), j = 0..ROOTS_NUM-1, and presents them through a valid/ready output register, with a nonzero-syndrome flag and a frame-length error flag.

---
 rtl/gf_pkg.sv | 62 ++++++
 rtl/rs_syndrome_lane.sv | 37 +++
 rtl/rs_syndrome.sv | 101 ++++++++++
 tb/tb_rs_syndrome.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gf_pkg.sv
// GF(2^8) definitions and RS(255,239) syndrome parameters.
package gf_pkg;
    localparam int SYMB_WIDTH        = 8;
    localparam int N_LEN             = 255;
    localparam int K_LEN             = 239;
    localparam int ROOTS_NUM         = N_LEN - K_LEN;
    localparam int BUS_WIDTH_IN_SYMB = 4;
    localparam int FIRST_ROOT        = 1;
    localparam int POLY              = 285;
    localparam int GF_ORDER          = (1 << SYMB_WIDTH) - 1;

    typedef logic [SYMB_WIDTH-1:0] symb_t;
    typedef symb_t syndr_t [ROOTS_NUM-1:0];
    typedef logic [BUS_WIDTH_IN_SYMB-1:0][SYMB_WIDTH-1:0] beat_t;

    localparam symb_t POLY_LO = POLY[SYMB_WIDTH-1:0];

    // Shift-and-add multiply. With one operand a constant, synthesis folds
    // it into a fixed XOR network (constant-coefficient multiplier).
    function automatic symb_t gf_mult(input symb_t a, input symb_t b);
        symb_t r;
        symb_t x;
        r = '0;
        x = a;
        for (int i = 0; i < SYMB_WIDTH; i++) begin
            if (b[i]) r = r ^ x;
            x = x[SYMB_WIDTH-1] ? ({x[SYMB_WIDTH-2:0], 1'b0} ^ POLY_LO)
                                : {x[SYMB_WIDTH-2:0], 1'b0};
        end
        return r;
    endfunction

    // alpha^e by square-and-multiply; keeps elaboration-time evaluation short.
    function automatic symb_t gf_alpha_pow(input int e);
        symb_t r;
        symb_t b;
        int    ee;
        ee = e % GF_ORDER;
        r  = {{(SYMB_WIDTH-1){1'b0}}, 1'b1};
        b  = {{(SYMB_WIDTH-2){1'b0}}, 2'b10};
        for (int i = 0; i < SYMB_WIDTH; i++) begin
            if (ee[i]) r = gf_mult(r, b);
            b = gf_mult(b, b);
        end
        return r;
    endfunction

    // alpha^((FIRST_ROOT+j)*k): the k-th power of syndrome root j.
    function automatic symb_t gf_root_pow(input int j, input int k);
        return gf_alpha_pow(((FIRST_ROOT + j) * k) % GF_ORDER);
    endfunction

    // Number of valid lanes; tkeep is contiguous from lane 0.
    function automatic int keep_count(input logic [BUS_WIDTH_IN_SYMB-1:0] k);
        int c;
        c = 0;
        for (int i = 0; i < BUS_WIDTH_IN_SYMB; i++) begin
            if (k[i]) c++;
        end
        return c;
    endfunction
endpackage

// File: rtl/rs_syndrome_lane.sv
// One syndrome accumulator update: acc*a^m ^ sum(lane_l * a^(m-1-l)).
module rs_syndrome_lane
    import gf_pkg::*;
#(
    parameter int J = 0
) (
    input  symb_t                          acc,
    input  beat_t                          lanes,
    input  logic [BUS_WIDTH_IN_SYMB-1:0]   keep,
    input  logic                           first,
    output symb_t                          acc_nxt
);
    symb_t pw [BUS_WIDTH_IN_SYMB+1];

    for (genvar k = 0; k <= BUS_WIDTH_IN_SYMB; k++) begin : g_pw
        localparam symb_t PW = gf_root_pow(J, k);
        assign pw[k] = PW;
    end

    symb_t acc_eff;
    int    m;

    // Horner step for every possible lane count, selected by popcount(keep).
    always_comb begin
        acc_eff = first ? '0 : acc;
        m       = keep_count(keep);
        acc_nxt = acc_eff;
        for (int mm = 0; mm <= BUS_WIDTH_IN_SYMB; mm++) begin
            if (m == mm) begin
                acc_nxt = gf_mult(acc_eff, pw[mm]);
                for (int l = 0; l < mm; l++) begin
                    acc_nxt = acc_nxt ^ gf_mult(lanes[l], pw[mm-1-l]);
                end
            end
        end
    end
endmodule

// File: rtl/rs_syndrome.sv
// Streaming RS syndrome calculator: per-root Horner accumulators,
// symbol counter and a valid/ready result register.
module rs_syndrome
    import gf_pkg::*;
(
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      s_tvalid,
    output logic                                      s_tready,
    input  logic [BUS_WIDTH_IN_SYMB*SYMB_WIDTH-1:0]   s_tdata,
    input  logic [BUS_WIDTH_IN_SYMB-1:0]              s_tkeep,
    input  logic                                      s_tlast,
    output logic                                      m_valid,
    input  logic                                      m_ready,
    output syndr_t                                    m_syndr,
    output logic                                      m_err,
    output logic                                      m_len_err
);
    // One extra bit over what N_LEN needs so the saturation value N_LEN+1
    // (any over-long frame) is representable.
    localparam int CNT_W   = $clog2(N_LEN + 2);
    localparam int CNT_MAX = N_LEN + 1;

    beat_t            lanes;
    syndr_t           acc_q, acc_d, acc_nxt;
    syndr_t           syndr_q, syndr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             first_q, first_d;
    logic             m_valid_q, m_valid_d;
    logic             err_q, err_d;
    logic             len_err_q, len_err_d;
    logic             xfer;
    logic             err_any;
    int               cnt_sum;
    int               cnt_sat;

    assign lanes     = s_tdata;
    assign s_tready  = !(m_valid_q && !m_ready);
    assign xfer      = s_tvalid && s_tready;
    assign m_valid   = m_valid_q;
    assign m_syndr   = syndr_q;
    assign m_err     = err_q;
    assign m_len_err = len_err_q;

    for (genvar j = 0; j < ROOTS_NUM; j++) begin : g_lane
        rs_syndrome_lane #(.J(j)) u_lane (
            .acc     (acc_q[j]),
            .lanes   (lanes),
            .keep    (s_tkeep),
            .first   (first_q),
            .acc_nxt (acc_nxt[j])
        );
    end

    // Next-state: accumulate on every transfer, close the frame on tlast.
    always_comb begin
        cnt_sum   = (first_q ? 0 : int'(cnt_q)) + keep_count(s_tkeep);
        cnt_sat   = (cnt_sum > CNT_MAX) ? CNT_MAX : cnt_sum;
        err_any   = 1'b0;
        for (int j = 0; j < ROOTS_NUM; j++) err_any = err_any | (|acc_nxt[j]);
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        first_d   = first_q;
        syndr_d   = syndr_q;
        err_d     = err_q;
        len_err_d = len_err_q;
        m_valid_d = m_valid_q && !m_ready;
        if (xfer) begin
            acc_d   = acc_nxt;
            cnt_d   = cnt_sat[CNT_W-1:0];
            first_d = s_tlast;
            if (s_tlast) begin
                syndr_d   = acc_nxt;
                err_d     = err_any;
                len_err_d = (cnt_sat != N_LEN);
                m_valid_d = 1'b1;
            end
        end
    end

    // State registers; reset discards any partial frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q     <= '{default: '0};
            syndr_q   <= '{default: '0};
            cnt_q     <= '0;
            first_q   <= 1'b1;
            m_valid_q <= 1'b0;
            err_q     <= 1'b0;
            len_err_q <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            syndr_q   <= syndr_d;
            cnt_q     <= cnt_d;
            first_q   <= first_d;
            m_valid_q <= m_valid_d;
            err_q     <= err_d;
            len_err_q <= len_err_d;
        end
    end
endmodule

// File: tb/tb_rs_syndrome.sv
// Directed bench for rs_syndrome with a direct-evaluation syndrome model.
module tb_rs_syndrome;
    import gf_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        s_tvalid;
    logic        s_tready;
    logic [31:0] s_tdata;
    logic [3:0]  s_tkeep;
    logic        s_tlast;
    logic        m_valid;
    logic        m_ready;
    syndr_t      m_syndr;
    logic        m_err;
    logic        m_len_err;

    int n_chk;
    int n_fail;
    int exp_t [0:254];
    int log_t [0:255];
    logic [7:0] frm [0:6][0:299];

    rs_syndrome dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_tvalid  (s_tvalid),
        .s_tready  (s_tready),
        .s_tdata   (s_tdata),
        .s_tkeep   (s_tkeep),
        .s_tlast   (s_tlast),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_syndr   (m_syndr),
        .m_err     (m_err),
        .m_len_err (m_len_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] tb_mul(input logic [7:0] a, input logic [7:0] b);
        if (a == 8'd0 || b == 8'd0) return 8'd0;
        return 8'(exp_t[(log_t[a] + log_t[b]) % 255]);
    endfunction

    // S_j = sum_i r_i * alpha^((1+j)*deg_i), deg of symbol i is n-1-i.
    function automatic logic [7:0] ref_syn(input int fi, input int n, input int j);
        logic [7:0] s;
        s = 8'd0;
        for (int i = 0; i < n; i++)
            s = s ^ tb_mul(frm[fi][i], 8'(exp_t[((FIRST_ROOT + j) * (n - 1 - i)) % 255]));
        return s;
    endfunction

    function automatic logic ref_or(input int fi, input int n);
        logic r;
        r = 1'b0;
        for (int j = 0; j < ROOTS_NUM; j++) r = r | (|ref_syn(fi, n, j));
        return r;
    endfunction

    task automatic drive_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
        int t;
        t = 0;
        @(negedge clk);
        s_tvalid = 1'b1; s_tdata = d; s_tkeep = k; s_tlast = l;
        #1;
        while (!s_tready && t < 300) begin
            @(negedge clk); #1; t++;
        end
        if (!s_tready) chk("beat_accept_timeout", 32'(s_tready), 32'd1);
        else begin
            @(posedge clk); #1;
        end
        s_tvalid = 1'b0;
    endtask

    task automatic send_frame(input int fi, input int nsym, input int stop_beats, input bit empty_last);
        int pos, nb, rem, m;
        bit lst, done;
        logic [31:0] d;
        logic [3:0] kp;
        pos = 0; nb = 0; done = 1'b0;
        while (!done) begin
            rem = nsym - pos;
            m   = (rem > 4) ? 4 : rem;
            lst = !empty_last && rem <= 4;
            if (empty_last && rem == 0) lst = 1'b1;
            d = '0; kp = '0;
            for (int l = 0; l < m; l++) begin
                d[8*l +: 8] = frm[fi][pos+l];
                kp[l] = 1'b1;
            end
            drive_beat(d, kp, lst);
            pos += m; nb++;
            done = lst || (stop_beats > 0 && nb == stop_beats);
        end
    endtask

    task automatic wait_valid();
        int t;
        t = 0;
        @(negedge clk);
        while (!m_valid && t < 400) begin
            @(negedge clk); t++;
        end
        chk("valid_timeout", 32'(m_valid), 32'd1);
    endtask

    task automatic consume();
        @(negedge clk); m_ready = 1'b1;
        @(negedge clk); m_ready = 1'b0;
    endtask

    task automatic check_syn(input int fi, input int n, input string tag);
        for (int j = 0; j < ROOTS_NUM; j++)
            chk($sformatf("%s_S%0d", tag, j), 32'(m_syndr[j]), 32'(ref_syn(fi, n, j)));
    endtask

    initial begin
        n_chk = 0; n_fail = 0;
        rst_n = 1'b0; s_tvalid = 1'b0; s_tdata = '0; s_tkeep = '0; s_tlast = 1'b0;
        m_ready = 1'b0;

        exp_t[0] = 1;
        for (int i = 1; i < 255; i++) begin
            exp_t[i] = exp_t[i-1] << 1;
            if (exp_t[i] > 255) exp_t[i] = exp_t[i] ^ 285;
        end
        log_t[0] = 0;
        for (int i = 0; i < 255; i++) log_t[exp_t[i]] = i;

        for (int f = 0; f < 7; f++)
            for (int i = 0; i < 300; i++) frm[f][i] = 8'd0;
        for (int i = 0; i < 300; i++) begin
            frm[0][i] = 8'((i * 37 + 11) % 256);
            frm[1][i] = 8'((i * 91 + 5) % 256);
            frm[5][i] = 8'((i * 53 + 200) % 256);
            frm[6][i] = 8'((i * 29 + 77) % 256);
        end
        frm[2][254] = 8'h05;
        frm[3][0]   = 8'h01;

        repeat (3) @(negedge clk);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_s_tready", 32'(s_tready), 32'd1);
        chk("rst_m_err", 32'(m_err), 32'd0);
        chk("rst_m_len_err", 32'(m_len_err), 32'd0);
        chk("rst_S0", 32'(m_syndr[0]), 32'd0);
        rst_n = 1'b1;

        // All-zero codeword, last beat keep=0111
        send_frame(4, 255, 0, 1'b0);
        chk("zero_latency", 32'(m_valid), 32'd1);
        for (int j = 0; j < ROOTS_NUM; j++) chk($sformatf("zero_S%0d", j), 32'(m_syndr[j]), 32'd0);
        chk("zero_err", 32'(m_err), 32'd0);
        chk("zero_len_err", 32'(m_len_err), 32'd0);
        consume();

        // Error 0x05 on the degree-0 symbol
        send_frame(2, 255, 0, 1'b0);
        chk("deg0_latency", 32'(m_valid), 32'd1);
        for (int j = 0; j < ROOTS_NUM; j++) chk($sformatf("deg0_S%0d", j), 32'(m_syndr[j]), 32'h05);
        chk("deg0_err", 32'(m_err), 32'd1);
        chk("deg0_len_err", 32'(m_len_err), 32'd0);
        consume();

        // Error 0x01 on the degree-254 symbol: S_j = alpha^-(j+1)
        send_frame(3, 255, 0, 1'b0);
        chk("deg254_S0", 32'(m_syndr[0]), 32'h8E);
        chk("deg254_S1", 32'(m_syndr[1]), 32'h47);
        for (int j = 2; j < ROOTS_NUM; j++)
            chk($sformatf("deg254_S%0d", j), 32'(m_syndr[j]), 32'(exp_t[255 - (j + 1)]));
        chk("deg254_err", 32'(m_err), 32'd1);
        consume();

        // Back-to-back frames, result held for 10 cycles
        fork
            begin
                send_frame(0, 255, 0, 1'b0);
                send_frame(1, 255, 0, 1'b0);
            end
            begin
                wait_valid();
                check_syn(0, 255, "b2bA");
                for (int c = 0; c < 10; c++) begin
                    @(negedge clk); #2;
                    chk("hold_s_tready", 32'(s_tready), 32'd0);
                    chk("hold_m_valid", 32'(m_valid), 32'd1);
                    chk("hold_S0", 32'(m_syndr[0]), 32'(ref_syn(0, 255, 0)));
                end
                @(negedge clk); m_ready = 1'b1;
                @(negedge clk); m_ready = 1'b0;
                wait_valid();
                check_syn(1, 255, "b2bB");
                chk("b2bB_len_err", 32'(m_len_err), 32'd0);
            end
        join
        consume();

        // Short frame: 60 full beats = 240 symbols
        send_frame(5, 240, 0, 1'b0);
        check_syn(5, 240, "short");
        chk("short_len_err", 32'(m_len_err), 32'd1);
        consume();
        send_frame(0, 255, 0, 1'b0);
        check_syn(0, 255, "after_short");
        chk("after_short_len_err", 32'(m_len_err), 32'd0);
        consume();

        // 252 symbols closed by an empty keep=0 tlast beat
        send_frame(6, 252, 0, 1'b1);
        chk("empty_last_valid", 32'(m_valid), 32'd1);
        check_syn(6, 252, "empty_last");
        chk("empty_last_len_err", 32'(m_len_err), 32'd1);
        consume();

        // Reset in the middle of a frame (after 30 beats)
        m_ready = 1'b1;
        send_frame(1, 255, 0, 1'b0);
        send_frame(0, 255, 30, 1'b0);
        chk("pre_rst_err", 32'(m_err), 32'(ref_or(1, 255)));
        @(negedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_m_valid", 32'(m_valid), 32'd0);
        chk("mid_rst_m_err", 32'(m_err), 32'd0);
        chk("mid_rst_m_len_err", 32'(m_len_err), 32'd0);
        chk("mid_rst_S0", 32'(m_syndr[0]), 32'd0);
        chk("mid_rst_S15", 32'(m_syndr[ROOTS_NUM-1]), 32'd0);
        chk("mid_rst_s_tready", 32'(s_tready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        m_ready = 1'b0;
        send_frame(0, 255, 0, 1'b0);
        check_syn(0, 255, "post_rst");
        chk("post_rst_len_err", 32'(m_len_err), 32'd0);
        consume();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
